aes_mm_queue: RTL and testbench
===============================

// Module: aes_mm_queue
// PURPOSE
//  Avalon-MM slave front end for the AES-128 core with a parametrised bus/block width,
//  a one-deep pending-command slot and a result FIFO of OUT_DEPTH blocks.
//  Supports back-to-back submissions without CPU polling, and raises an optional level interrupt.
//  Sits between the Nios/Avalon fabric and AES_Top; the core handshake is exposed as ports.
// PARAMETERS
//  BUS_W      32   Avalon data width; BLOCK_W must be a multiple of BUS_W.
//  BLOCK_W    128  Cipher block / key width.
//  OUT_DEPTH  4    Result FIFO depth in blocks; power of two, >=2.
//  localparam WORDS = BLOCK_W/BUS_W; ADDR_W = $clog2(WORDS+2); CNT_W = $clog2(OUT_DEPTH+1).
// PORTS
//  iClk           in   1        Clock.
//  iReset_n       in   1        Asynchronous, active-low reset.
//  iChipSelect_n  in   1        Avalon chip select, active-low.
//  iWrite_n       in   1        Avalon write strobe, active-low.
//  iRead_n        in   1        Avalon read strobe, active-low.
//  iAddress       in   ADDR_W   Word address.
//  iData          in   BUS_W    Write data.
//  oData          out  BUS_W    Registered read data.
//  oIrq           out  1        Level interrupt.
//  oCoreData      out  BLOCK_W  Block/key presented to the core.
//  oLoadData      out  1        One-cycle pulse: core consumes oCoreData as plaintext.
//  oLoadKey       out  1        One-cycle pulse: core consumes oCoreData as key.
//  iCoreReady     in   1        Core can accept a new load.
//  iCTValid       in   1        Core result valid, one cycle per block.
//  iCipherText    in   BLOCK_W  Core result.
// BEHAVIOUR
//  Register map (word addresses):
//   0..WORDS-1  W: staging word; word 0 = MSBs.
//               R: word i of the result FIFO head; reads 0 if the FIFO is empty.
//   WORDS       W: CMD. bit0 = START_DATA, bit1 = LOAD_KEY, bit2 = POP, bit3 = CLR_ERR.
//               R: STATUS = {.., count[CNT_W], cmd_err, ovf, full, empty, pending, iCoreReady} (LSB right).
//   WORDS+1     R/W: CTRL. bit0 = irq_en.
//  Access rules:
//   - An access is active when iChipSelect_n and the strobe are both low.
//   - Reads: oData is registered, 1-cycle latency. A read in the same cycle as a write sees pre-write state.
//   - Reads of unmapped addresses return 0; writes to unmapped addresses are ignored.
//  Command accept:
//   - START_DATA or LOAD_KEY with no pending command: snapshot the staging words into cmd_blk,
//     set pending, and latch the kind (data/key).
//   - START_DATA and LOAD_KEY both set: LOAD_KEY wins.
//   - Command while pending: dropped, cmd_err is set (sticky); staging and cmd_blk are untouched.
//  Issue:
//   - When pending && iCoreReady, pulse oLoadData or oLoadKey for exactly 1 cycle and clear pending that cycle.
//   - Earliest pulse is the cycle after the CMD write.
//   - oCoreData = cmd_blk and is stable from accept through issue; staging writes never disturb it.
//  Result FIFO:
//   - iCTValid pushes iCipherText.
//   - Push while full: block dropped, ovf set (sticky).
//   - POP removes the head. POP while empty: no-op, no error.
//   - Push and POP in the same cycle: both succeed, count unchanged. This also holds when full (no ovf).
//   - Pointers wrap modulo OUT_DEPTH.
//  CLR_ERR clears ovf and cmd_err. It may share a CMD write with POP or a command; both actions take effect.
//  oIrq is registered: irq_en & (~empty | ovf).
//  Reset values:
//   - oData, oCoreData, oLoadData, oLoadKey, oIrq, staging, cmd_blk, pending, irq_en, ovf, cmd_err, count = 0.
//   - FIFO empty.
//   - Reset mid-operation discards the pending command and all queued results.
// STRUCTURE
//  Package aes_mm_pkg: register offsets relative to WORDS, CMD bit indices, STATUS/CTRL bit positions.
//  Sub-module aes_result_fifo #(W, DEPTH): synchronous FIFO providing push/pop/full/empty/count
//  and first-word-fall-through head output.
//  Top level: staging registers, command slot, Avalon decode/readback, irq logic.
// TESTING
//  1. Reset only: every output 0; STATUS reads empty=1, count=0.
//  2. Write staging 0x00112233.. ; CMD=2 with iCoreReady=1:
//     oLoadKey pulses 1 cycle next cycle; oCoreData equals the staged value.
//  3. CMD=1 with iCoreReady=0 for 10 cycles, then a second CMD=1:
//     cmd_err=1; exactly one oLoadData pulse after iCoreReady rises.
//  4. Five iCTValid pulses with OUT_DEPTH=4 and no POP: count=4, full=1, ovf=1;
//     data words return blocks 1..4 in order across POPs.
//  5. Full FIFO with iCTValid and a POP write in the same cycle: count stays 4, ovf stays 0,
//     head advances to block 2.
//  6. CTRL=1 then one result: oIrq=1; POP to empty gives oIrq=0.
//     Assert iReset_n low mid-queue: FIFO empty, oIrq=0 asynchronously.

Source files
------------

// File: rtl/aes_mm_pkg.sv
// Purpose: shared definitions for the AES Avalon-MM queue front end.
//   Register offsets are relative to WORDS, the first address after the
//   staging/result data words.
// Ports: none (package).
package aes_mm_pkg;

    // Register offsets above the data words
    localparam int unsigned OFS_CMD  = 0;
    localparam int unsigned OFS_CTRL = 1;

    // CMD register bits
    localparam int unsigned CMD_START_DATA = 0;
    localparam int unsigned CMD_LOAD_KEY   = 1;
    localparam int unsigned CMD_POP        = 2;
    localparam int unsigned CMD_CLR_ERR    = 3;

    // STATUS register bits; the FIFO count occupies ST_COUNT upwards
    localparam int unsigned ST_CORE_READY = 0;
    localparam int unsigned ST_PENDING    = 1;
    localparam int unsigned ST_EMPTY      = 2;
    localparam int unsigned ST_FULL       = 3;
    localparam int unsigned ST_OVF        = 4;
    localparam int unsigned ST_CMD_ERR    = 5;
    localparam int unsigned ST_COUNT      = 6;

    // CTRL register bits
    localparam int unsigned CTRL_IRQ_EN = 0;

    // Kind of the command waiting in the pending slot
    typedef enum logic {
        KIND_DATA = 1'b0,
        KIND_KEY  = 1'b1
    } cmd_kind_e;

endpackage

// File: rtl/aes_result_fifo.sv
// Purpose: synchronous result FIFO with first-word-fall-through head.
//   A push is accepted when not full, or when a pop succeeds in the same
//   cycle; a pop on an empty FIFO is ignored.
// Ports:
//   iClk, iReset_n  clock, asynchronous active-low reset
//   i_push, i_din   push request and data
//   i_pop           pop request
//   o_head          current head entry (undefined content when empty)
//   o_full, o_empty, o_count  occupancy
module aes_result_fifo #(
    parameter  int unsigned W     = 128,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             i_push,
    input  logic [W-1:0]     i_din,
    input  logic             i_pop,
    output logic [W-1:0]     o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still succeeds
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/aes_mm_queue.sv
// Purpose: Avalon-MM slave front end for the AES-128 core. Holds staging
//   words, a one-deep pending command slot feeding the core, and a result
//   FIFO read back over the bus, with an optional level interrupt.
// Ports:
//   iClk, iReset_n            clock, asynchronous active-low reset
//   iChipSelect_n, iWrite_n, iRead_n, iAddress, iData, oData   Avalon slave
//   oIrq                      level interrupt
//   oCoreData, oLoadData, oLoadKey, iCoreReady   command handshake to core
//   iCTValid, iCipherText     result from core
module aes_mm_queue
    import aes_mm_pkg::*;
#(
    parameter  int unsigned BUS_W     = 32,
    parameter  int unsigned BLOCK_W   = 128,
    parameter  int unsigned OUT_DEPTH = 4,
    localparam int unsigned WORDS     = BLOCK_W / BUS_W,
    localparam int unsigned ADDR_W    = $clog2(WORDS + 2),
    localparam int unsigned CNT_W     = $clog2(OUT_DEPTH + 1)
) (
    input  logic               iClk,
    input  logic               iReset_n,
    input  logic               iChipSelect_n,
    input  logic               iWrite_n,
    input  logic               iRead_n,
    input  logic [ADDR_W-1:0]  iAddress,
    input  logic [BUS_W-1:0]   iData,
    output logic [BUS_W-1:0]   oData,
    output logic               oIrq,
    output logic [BLOCK_W-1:0] oCoreData,
    output logic               oLoadData,
    output logic               oLoadKey,
    input  logic               iCoreReady,
    input  logic               iCTValid,
    input  logic [BLOCK_W-1:0] iCipherText
);

    logic [BUS_W-1:0]   r_stage [WORDS];
    logic [BLOCK_W-1:0] r_cmd_blk;
    logic               r_pending;
    cmd_kind_e          r_kind;
    logic               r_irq_en;
    logic               r_ovf;
    logic               r_cmd_err;
    logic [BUS_W-1:0]   r_rdata;
    logic               r_irq;

    logic               w_wr, w_rd;
    logic               w_cmd_wr, w_ctrl_wr;
    logic               w_start, w_key, w_pop, w_clr;
    logic               w_accept, w_drop, w_issue, w_ovf_set;
    logic [BLOCK_W-1:0] w_stage_blk;
    logic [BLOCK_W-1:0] w_head;
    logic               w_full, w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [BUS_W-1:0]   w_status;
    logic [BUS_W-1:0]   w_rdata;

    assign w_wr      = !iChipSelect_n && !iWrite_n;
    assign w_rd      = !iChipSelect_n && !iRead_n;
    assign w_cmd_wr  = w_wr && (iAddress == ADDR_W'(WORDS + OFS_CMD));
    assign w_ctrl_wr = w_wr && (iAddress == ADDR_W'(WORDS + OFS_CTRL));
    assign w_start   = w_cmd_wr && iData[CMD_START_DATA];
    assign w_key     = w_cmd_wr && iData[CMD_LOAD_KEY];
    assign w_pop     = w_cmd_wr && iData[CMD_POP];
    assign w_clr     = w_cmd_wr && iData[CMD_CLR_ERR];
    assign w_accept  = (w_start || w_key) && !r_pending;
    assign w_drop    = (w_start || w_key) && r_pending;
    assign w_issue   = r_pending && iCoreReady;
    // Full implies non-empty, so any pop request here frees a slot
    assign w_ovf_set = iCTValid && w_full && !w_pop;

    assign oLoadData = w_issue && (r_kind == KIND_DATA);
    assign oLoadKey  = w_issue && (r_kind == KIND_KEY);
    assign oCoreData = r_cmd_blk;
    assign oData     = r_rdata;
    assign oIrq      = r_irq;

    // Staging word 0 carries the block MSBs
    always_comb begin
        w_stage_blk = '0;
        for (int unsigned i = 0; i < WORDS; i++)
            w_stage_blk[(WORDS-1-i)*BUS_W +: BUS_W] = r_stage[i];
    end

    aes_result_fifo #(
        .W     (BLOCK_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .i_push   (iCTValid),
        .i_din    (iCipherText),
        .i_pop    (w_pop),
        .o_head   (w_head),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_count  (w_count)
    );

    always_comb begin
        w_status                  = '0;
        w_status[ST_CORE_READY]   = iCoreReady;
        w_status[ST_PENDING]      = r_pending;
        w_status[ST_EMPTY]        = w_empty;
        w_status[ST_FULL]         = w_full;
        w_status[ST_OVF]          = r_ovf;
        w_status[ST_CMD_ERR]      = r_cmd_err;
        w_status[ST_COUNT +: CNT_W] = w_count;
    end

    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < WORDS; i++)
            if (iAddress == ADDR_W'(i) && !w_empty)
                w_rdata = w_head[(WORDS-1-i)*BUS_W +: BUS_W];
        if (iAddress == ADDR_W'(WORDS + OFS_CMD))
            w_rdata = w_status;
        if (iAddress == ADDR_W'(WORDS + OFS_CTRL))
            w_rdata[CTRL_IRQ_EN] = r_irq_en;
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            for (int unsigned i = 0; i < WORDS; i++) r_stage[i] <= '0;
            r_cmd_blk <= '0;
            r_pending <= 1'b0;
            r_kind    <= KIND_DATA;
            r_irq_en  <= 1'b0;
            r_ovf     <= 1'b0;
            r_cmd_err <= 1'b0;
            r_rdata   <= '0;
            r_irq     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < WORDS; i++)
                if (w_wr && iAddress == ADDR_W'(i)) r_stage[i] <= iData;

            // Accept needs an empty slot, so it can never coincide with issue
            if (w_accept) begin
                r_cmd_blk <= w_stage_blk;
                r_pending <= 1'b1;
                r_kind    <= w_key ? KIND_KEY : KIND_DATA;
            end else if (w_issue) begin
                r_pending <= 1'b0;
            end

            // Clear first so an error arising in the same cycle is kept
            if (w_clr) begin
                r_ovf     <= 1'b0;
                r_cmd_err <= 1'b0;
            end
            if (w_ovf_set) r_ovf     <= 1'b1;
            if (w_drop)    r_cmd_err <= 1'b1;

            if (w_ctrl_wr) r_irq_en <= iData[CTRL_IRQ_EN];
            if (w_rd)      r_rdata  <= w_rdata;
            r_irq <= r_irq_en && (!w_empty || r_ovf);
        end
    end

endmodule

// File: tb/tb_aes_mm_queue.sv
module tb_aes_mm_queue;

    localparam logic [2:0] A_CMD  = 3'd4;
    localparam logic [2:0] A_CTRL = 3'd5;

    logic         iClk = 1'b0;
    logic         iReset_n = 1'b0;
    logic         iChipSelect_n = 1'b1;
    logic         iWrite_n = 1'b1;
    logic         iRead_n = 1'b1;
    logic [2:0]   iAddress = '0;
    logic [31:0]  iData = '0;
    logic [31:0]  oData;
    logic         oIrq;
    logic [127:0] oCoreData;
    logic         oLoadData;
    logic         oLoadKey;
    logic         iCoreReady = 1'b0;
    logic         iCTValid = 1'b0;
    logic [127:0] iCipherText = '0;

    aes_mm_queue #(.BUS_W(32), .BLOCK_W(128), .OUT_DEPTH(4)) dut (
        .iClk          (iClk),
        .iReset_n      (iReset_n),
        .iChipSelect_n (iChipSelect_n),
        .iWrite_n      (iWrite_n),
        .iRead_n       (iRead_n),
        .iAddress      (iAddress),
        .iData         (iData),
        .oData         (oData),
        .oIrq          (oIrq),
        .oCoreData     (oCoreData),
        .oLoadData     (oLoadData),
        .oLoadKey      (oLoadKey),
        .iCoreReady    (iCoreReady),
        .iCTValid      (iCTValid),
        .iCipherText   (iCipherText)
    );

    always #5 iClk = ~iClk;

    int n_pass = 0;
    int n_total = 0;
    int n_ld = 0;
    int n_lk = 0;

    always @(posedge iClk) begin
        if (iReset_n) begin
            if (oLoadData) n_ld++;
            if (oLoadKey)  n_lk++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] status(input int cnt, input bit err, input bit ovf,
                                           input bit full, input bit empty, input bit pend,
                                           input bit rdy);
        return (32'(cnt) << 6) | {26'd0, err, ovf, full, empty, pend, rdy};
    endfunction

    function automatic logic [127:0] blk(input int k);
        return {32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k),
                32'h3000_0000 + 32'(k), 32'h4000_0000 + 32'(k)};
    endfunction

    task automatic do_reset();
        iReset_n = 1'b0;
        iChipSelect_n = 1'b1; iWrite_n = 1'b1; iRead_n = 1'b1; iCTValid = 1'b0;
        #20;
        @(negedge iClk); iReset_n = 1'b1;
        @(posedge iClk); #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d,
                             input bit ct_en = 1'b0, input logic [127:0] ct = '0);
        @(negedge iClk);
        iChipSelect_n = 1'b0; iWrite_n = 1'b0; iAddress = a; iData = d;
        iCTValid = ct_en; iCipherText = ct;
        @(posedge iClk); #1;
        iChipSelect_n = 1'b1; iWrite_n = 1'b1; iCTValid = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge iClk);
        iChipSelect_n = 1'b0; iRead_n = 1'b0; iAddress = a;
        @(posedge iClk); #1;
        d = oData;
        iChipSelect_n = 1'b1; iRead_n = 1'b1;
    endtask

    task automatic push_ct(input logic [127:0] b);
        @(negedge iClk); iCTValid = 1'b1; iCipherText = b;
        @(posedge iClk); #1; iCTValid = 1'b0;
    endtask

    task automatic read_head(output logic [127:0] b);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            bus_read(3'(i), w);
            b[(3-i)*32 +: 32] = w;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    typedef struct {
        bit          rd;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vt[12];

    // reference model state
    logic [127:0] m_q[$];
    logic [31:0]  m_stage[4];
    logic [127:0] m_blk;
    bit m_pend, m_key, m_ovf, m_err, m_irq_en;

    initial begin
        logic [31:0]  rd;
        logic [127:0] b;
        int ld0, lk0;

        vt[0]  = '{1'b1, A_CMD,  32'h0,          32'h4, "status_reset"};
        vt[1]  = '{1'b1, 3'd0,   32'h0,          32'h0, "head_w0_empty"};
        vt[2]  = '{1'b1, 3'd3,   32'h0,          32'h0, "head_w3_empty"};
        vt[3]  = '{1'b0, A_CTRL, 32'h1,          32'h0, ""};
        vt[4]  = '{1'b1, A_CTRL, 32'h0,          32'h1, "ctrl_rd1"};
        vt[5]  = '{1'b0, A_CTRL, 32'hFFFF_FFFE,  32'h0, ""};
        vt[6]  = '{1'b1, A_CTRL, 32'h0,          32'h0, "ctrl_rd0"};
        vt[7]  = '{1'b0, 3'd6,   32'hDEAD_BEEF,  32'h0, ""};
        vt[8]  = '{1'b1, 3'd6,   32'h0,          32'h0, "unmapped6"};
        vt[9]  = '{1'b1, 3'd7,   32'h0,          32'h0, "unmapped7"};
        vt[10] = '{1'b0, A_CMD,  32'h4,          32'h0, ""};
        vt[11] = '{1'b1, A_CMD,  32'h0,          32'h4, "status_pop_empty"};

        // 1. reset state
        #3;
        check("rst_oData", oData, 0);
        check("rst_oIrq", oIrq, 0);
        check("rst_oCoreData", oCoreData, 0);
        check("rst_oLoadData", oLoadData, 0);
        check("rst_oLoadKey", oLoadKey, 0);
        do_reset();

        // register map table
        for (int i = 0; i < 12; i++) begin
            if (vt[i].rd) begin
                bus_read(vt[i].addr, rd);
                check(vt[i].name, rd, vt[i].exp);
            end else begin
                bus_write(vt[i].addr, vt[i].data);
            end
        end

        // 2. key load with core ready
        iCoreReady = 1'b1;
        bus_write(0, 32'h0011_2233); bus_write(1, 32'h4455_6677);
        bus_write(2, 32'h8899_AABB); bus_write(3, 32'hCCDD_EEFF);
        lk0 = n_lk; ld0 = n_ld;
        bus_write(A_CMD, 32'h2);
        check("key_pulse", oLoadKey, 1);
        check("key_no_data", oLoadData, 0);
        check("key_coredata", oCoreData, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        idle(1);
        check("key_pulse_end", oLoadKey, 0);
        check("key_pulse_count", n_lk - lk0, 1);
        check("key_no_data_count", n_ld - ld0, 0);
        bus_read(A_CMD, rd);
        check("status_after_key", rd, status(0, 0, 0, 0, 1, 0, 1));

        // 3. data command held while core busy, second command dropped
        iCoreReady = 1'b0;
        bus_write(0, 32'hA0A0_A0A0); bus_write(1, 32'hA1A1_A1A1);
        bus_write(2, 32'hA2A2_A2A2); bus_write(3, 32'hA3A3_A3A3);
        ld0 = n_ld;
        bus_write(A_CMD, 32'h1);
        idle(10);
        check("busy_no_pulse", n_ld - ld0, 0);
        bus_write(0, 32'hFFFF_FFFF);
        check("coredata_stable", oCoreData, 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3);
        bus_write(A_CMD, 32'h1);
        bus_read(A_CMD, rd);
        check("status_cmd_err", rd, status(0, 1, 0, 0, 1, 1, 0));
        iCoreReady = 1'b1;
        idle(5);
        check("one_data_pulse", n_ld - ld0, 1);
        check("coredata_kept", oCoreData, 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3);
        bus_read(A_CMD, rd);
        check("status_issued", rd, status(0, 1, 0, 0, 1, 0, 1));
        bus_write(A_CMD, 32'h8);
        bus_read(A_CMD, rd);
        check("status_clr_err", rd, status(0, 0, 0, 0, 1, 0, 1));

        // 4. overflow and in-order readback
        for (int k = 1; k <= 5; k++) push_ct(blk(k));
        bus_read(A_CMD, rd);
        check("status_ovf", rd, status(4, 0, 1, 1, 0, 0, 1));
        for (int k = 1; k <= 4; k++) begin
            read_head(b);
            check($sformatf("fifo_order_%0d", k), b, blk(k));
            bus_write(A_CMD, 32'h4);
        end
        bus_read(A_CMD, rd);
        check("status_drained", rd, status(0, 0, 1, 0, 1, 0, 1));
        bus_write(A_CMD, 32'h8);

        // 5. push and pop together while full
        for (int k = 1; k <= 4; k++) push_ct(blk(k));
        bus_write(A_CMD, 32'h4, 1'b1, blk(5));
        bus_read(A_CMD, rd);
        check("status_full_pushpop", rd, status(4, 0, 0, 1, 0, 0, 1));
        for (int k = 2; k <= 5; k++) begin
            read_head(b);
            check($sformatf("pushpop_order_%0d", k), b, blk(k));
            bus_write(A_CMD, 32'h4);
        end

        // 6. interrupt and asynchronous reset
        bus_write(A_CTRL, 32'h1);
        idle(2);
        check("irq_empty", oIrq, 0);
        push_ct(blk(7));
        idle(2);
        check("irq_set", oIrq, 1);
        bus_write(A_CMD, 32'h4);
        idle(2);
        check("irq_clear", oIrq, 0);
        push_ct(blk(8)); push_ct(blk(9));
        idle(2);
        check("irq_set2", oIrq, 1);
        @(negedge iClk); #2;
        iReset_n = 1'b0;
        #1;
        check("async_rst_irq", oIrq, 0);
        check("async_rst_coredata", oCoreData, 0);
        #10;
        @(negedge iClk); iReset_n = 1'b1;
        idle(1);
        bus_read(A_CMD, rd);
        check("status_after_rst", rd, status(0, 0, 0, 0, 1, 0, 1));
        bus_read(0, rd);
        check("head_after_rst", rd, 0);

        // randomized run against the reference model
        do_reset();
        m_q.delete();
        for (int i = 0; i < 4; i++) m_stage[i] = '0;
        m_blk = '0; m_pend = 0; m_key = 0; m_ovf = 0; m_err = 0; m_irq_en = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int op;
            bit wr, rdop, rdy, ctv, pre_pend;
            logic [2:0] a;
            logic [31:0] d, exp_rd;
            logic [127:0] ct, h;
            bit exp_irq;
            op = $urandom_range(0, 9);
            rdy = ($urandom_range(0, 1) == 1);
            ctv = ($urandom_range(0, 2) == 0);
            ct = {$urandom, $urandom, $urandom, $urandom};
            d = $urandom;
            wr = 0; rdop = 0; a = 0;
            if (op <= 2)      begin wr = 1; a = 3'($urandom_range(0, 3)); end
            else if (op <= 4) begin wr = 1; a = A_CMD; d = 32'($urandom_range(0, 15)); end
            else if (op <= 7) begin rdop = 1; a = 3'($urandom_range(0, 7)); end
            else if (op == 8) begin wr = 1; a = A_CTRL; end
            @(negedge iClk);
            iChipSelect_n = !(wr || rdop); iWrite_n = !wr; iRead_n = !rdop;
            iAddress = a; iData = d; iCoreReady = rdy; iCTValid = ctv; iCipherText = ct;
            #1;
            check("rnd_load_data", oLoadData, m_pend && rdy && !m_key);
            check("rnd_load_key", oLoadKey, m_pend && rdy && m_key);
            if (m_pend && rdy) check("rnd_coredata", oCoreData, m_blk);
            exp_rd = 0;
            if (a < 4) begin
                if (m_q.size() > 0) begin h = m_q[0]; exp_rd = h[(3 - a)*32 +: 32]; end
            end else if (a == A_CMD) begin
                exp_rd = status(m_q.size(), m_err, m_ovf, m_q.size() == 4, m_q.size() == 0, m_pend, rdy);
            end else if (a == A_CTRL) begin
                exp_rd = {31'd0, m_irq_en};
            end
            exp_irq = m_irq_en && (m_q.size() > 0 || m_ovf);
            @(posedge iClk); #1;
            check("rnd_irq", oIrq, exp_irq);
            if (rdop) check("rnd_read", oData, exp_rd);
            // model update
            pre_pend = m_pend;
            if (m_pend && rdy) m_pend = 0;
            if (wr && a < 4) m_stage[a] = d;
            if (wr && a == A_CTRL) m_irq_en = d[0];
            if (wr && a == A_CMD) begin
                if (d[3]) begin m_ovf = 0; m_err = 0; end
                if (d[0] || d[1]) begin
                    if (pre_pend) m_err = 1;
                    else begin
                        m_pend = 1; m_key = d[1];
                        m_blk = {m_stage[0], m_stage[1], m_stage[2], m_stage[3]};
                    end
                end
                if (d[2] && m_q.size() > 0) void'(m_q.pop_front());
            end
            if (ctv) begin
                if (m_q.size() < 4) m_q.push_back(ct);
                else m_ovf = 1;
            end
        end
        iChipSelect_n = 1'b1; iWrite_n = 1'b1; iRead_n = 1'b1; iCTValid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
